// File: rtl/view_ctrl_pkg.sv
// Shared types and helpers for the background view sequencer.
package view_ctrl_pkg;

   typedef enum logic [2:0] {OFFICE, OPEN, VIEW, SWITCH, PWR} state_t;

   localparam int OFFICE_VIEW = 0;

   // Circular step through camera indices 0..num_cams-1.
   function automatic int wrap_step(input int cam, input int num_cams, input bit fwd);
      if (fwd) return (cam == num_cams - 1) ? 0 : cam + 1;
      else     return (cam == 0) ? num_cams - 1 : cam - 1;
   endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Detects the first pixel of vertical blank and emits a registered one-cycle frame strobe.
module frame_tick_gen #(
   parameter int V_ACTIVE = 480
)(
   input  logic       vga_clk,
   input  logic       Reset,
   input  logic [9:0] DrawX,
   input  logic [9:0] DrawY,
   output logic       tick_now,
   output logic       frame_tick
);

   assign tick_now = (DrawX == 10'd0) && (DrawY == 10'(V_ACTIVE));

   always_ff @(posedge vga_clk) begin
      if (Reset) frame_tick <= 1'b0;
      else       frame_tick <= tick_now;
   end

endmodule

// File: rtl/view_switch_controller.sv
// Scene sequencer: latches keyboard requests and applies view changes only at vblank start.
module view_switch_controller
   import view_ctrl_pkg::*;
#(
   parameter int NUM_CAMS      = 6,
   parameter int STATIC_FRAMES = 8,
   parameter int H_ACTIVE      = 640,
   parameter int V_ACTIVE      = 480
)(
   input  logic                             vga_clk,
   input  logic                             Reset,
   input  logic [9:0]                       DrawX,
   input  logic [9:0]                       DrawY,
   input  logic                             blank,
   input  logic                             cam_toggle,
   input  logic                             cam_next,
   input  logic                             cam_prev,
   input  logic                             sel_valid,
   input  logic [$clog2(NUM_CAMS)-1:0]      sel_cam,
   input  logic                             power_out,
   output logic [$clog2(NUM_CAMS+1)-1:0]    view_id,
   output logic                             static_en,
   output logic [$clog2(STATIC_FRAMES+1)-1:0] static_cnt,
   output logic                             dark,
   output logic                             busy,
   output logic                             frame_tick
);

   localparam int CW = $clog2(NUM_CAMS);
   localparam int VW = $clog2(NUM_CAMS + 1);
   localparam int SW = $clog2(STATIC_FRAMES + 1);

   state_t        state_reg;
   logic [CW-1:0] cur_cam_reg, pend_tgt_reg, nav_base, cam_fwd, cam_back;
   logic          pend_toggle_reg, pend_nav_reg;
   logic          tick_now, sel_ok, power_cut, nav_dropped;
   logic          unused_inputs;

   // The vblank strobe comes from raster position alone; blank and line width are not needed.
   assign unused_inputs = blank & (DrawX < 10'(H_ACTIVE));

   frame_tick_gen #(.V_ACTIVE(V_ACTIVE)) u_tick (
      .vga_clk    (vga_clk),
      .Reset      (Reset),
      .DrawX      (DrawX),
      .DrawY      (DrawY),
      .tick_now   (tick_now),
      .frame_tick (frame_tick)
   );

   // A nav dropped on this tick must not seed a fresh next/prev from its stale target.
   assign nav_dropped = tick_now && ((state_reg == OFFICE) || (state_reg == VIEW && pend_toggle_reg));
   assign nav_base    = (pend_nav_reg && !nav_dropped) ? pend_tgt_reg : cur_cam_reg;
   assign cam_fwd     = CW'(wrap_step(int'(nav_base), NUM_CAMS, 1'b1));
   assign cam_back    = CW'(wrap_step(int'(nav_base), NUM_CAMS, 1'b0));
   assign sel_ok      = sel_valid && (int'(sel_cam) < NUM_CAMS);
   assign power_cut   = tick_now && power_out && (state_reg != PWR);

   always_ff @(posedge vga_clk) begin
      if (Reset) begin
         state_reg       <= OFFICE;
         cur_cam_reg     <= '0;
         pend_tgt_reg    <= '0;
         pend_toggle_reg <= 1'b0;
         pend_nav_reg    <= 1'b0;
         view_id         <= VW'(OFFICE_VIEW);
         static_en       <= 1'b0;
         static_cnt      <= '0;
         dark            <= 1'b0;
         busy            <= 1'b0;
      end else begin
         if (power_cut) begin
            state_reg  <= PWR;
            dark       <= 1'b1;
            view_id    <= VW'(OFFICE_VIEW);
            static_en  <= 1'b0;
            static_cnt <= '0;
            busy       <= 1'b0;
         end else if (tick_now) begin
            case (state_reg)
               OFFICE: begin
                  if (pend_toggle_reg) begin
                     state_reg  <= OPEN;
                     view_id    <= VW'(cur_cam_reg) + VW'(1);
                     static_cnt <= SW'(STATIC_FRAMES);
                     static_en  <= 1'b1;
                     busy       <= 1'b1;
                  end
                  pend_toggle_reg <= 1'b0;
                  pend_nav_reg    <= 1'b0;
               end
               OPEN, SWITCH: begin
                  static_cnt <= static_cnt - SW'(1);
                  if (static_cnt == SW'(1)) begin
                     state_reg <= VIEW;
                     static_en <= 1'b0;
                     busy      <= 1'b0;
                  end
               end
               VIEW: begin
                  if (pend_toggle_reg) begin
                     state_reg <= OFFICE;
                     view_id   <= VW'(OFFICE_VIEW);
                  end else if (pend_nav_reg && pend_tgt_reg != cur_cam_reg) begin
                     state_reg   <= SWITCH;
                     cur_cam_reg <= pend_tgt_reg;
                     view_id     <= VW'(pend_tgt_reg) + VW'(1);
                     static_cnt  <= SW'(STATIC_FRAMES);
                     static_en   <= 1'b1;
                     busy        <= 1'b1;
                  end
                  pend_toggle_reg <= 1'b0;
                  pend_nav_reg    <= 1'b0;
               end
               PWR: begin
                  if (!power_out) begin
                     state_reg <= OFFICE;
                     dark      <= 1'b0;
                  end
               end
               default: state_reg <= OFFICE;
            endcase
         end

         // Capture comes after consumption so a pulse on the tick edge survives to the next frame.
         if (state_reg == PWR || power_cut) begin
            pend_toggle_reg <= 1'b0;
            pend_nav_reg    <= 1'b0;
            pend_tgt_reg    <= '0;
         end else begin
            if (cam_toggle) pend_toggle_reg <= 1'b1;
            if (sel_ok) begin
               pend_nav_reg <= 1'b1;
               pend_tgt_reg <= sel_cam;
            end else if (cam_next) begin
               pend_nav_reg <= 1'b1;
               pend_tgt_reg <= cam_fwd;
            end else if (cam_prev) begin
               pend_nav_reg <= 1'b1;
               pend_tgt_reg <= cam_back;
            end
         end
      end
   end

endmodule

// File: tb/tb_view_switch_controller.sv
// Bench for view_switch_controller: short synthetic raster, table of per-frame requests, scoreboard at each tick.
module tb_view_switch_controller;

   typedef struct packed {
      logic [2:0] v;
      logic       se;
      logic [3:0] c;
      logic       dk;
      logic       bz;
   } out_t;

   typedef struct {
      logic       tog, nxt, prv, sv;
      logic [2:0] sc;
      logic       pwr;
      out_t       exp;
   } vec_t;

   typedef struct {
      out_t  o;
      string name;
   } sb_t;

   logic       vga_clk = 1'b0;
   logic       Reset = 1'b1;
   logic [9:0] DrawX, DrawY;
   logic       blank;
   logic       cam_toggle = 1'b0, cam_next = 1'b0, cam_prev = 1'b0, sel_valid = 1'b0;
   logic [2:0] sel_cam = 3'd0;
   logic       power_out = 1'b0;
   logic [2:0] view_id;
   logic       static_en;
   logic [3:0] static_cnt;
   logic       dark, busy, frame_tick;

   logic [3:0] cnt = 4'd0;
   logic       prev_tick = 1'b0;
   int         total = 0;
   int         bad = 0;
   vec_t       tbl[$];
   sb_t        sbq[$];
   int         split1, split2;

   view_switch_controller dut (
      .vga_clk    (vga_clk),
      .Reset      (Reset),
      .DrawX      (DrawX),
      .DrawY      (DrawY),
      .blank      (blank),
      .cam_toggle (cam_toggle),
      .cam_next   (cam_next),
      .cam_prev   (cam_prev),
      .sel_valid  (sel_valid),
      .sel_cam    (sel_cam),
      .power_out  (power_out),
      .view_id    (view_id),
      .static_en  (static_en),
      .static_cnt (static_cnt),
      .dark       (dark),
      .busy       (busy),
      .frame_tick (frame_tick)
   );

   always #5 vga_clk = ~vga_clk;

   // 16-cycle miniature frame; DrawY sits on the vblank row for several columns, only column 0 may tick.
   always @(posedge vga_clk) cnt <= cnt + 4'd1;
   assign DrawX = {6'd0, cnt};
   assign DrawY = (cnt < 4'd4) ? 10'd480 : 10'd200;
   assign blank = (cnt >= 4'd4);

   function automatic out_t mk(input int v, input bit se, input int c, input bit dk, input bit bz);
      out_t o;
      o.v = 3'(v); o.se = se; o.c = 4'(c); o.dk = dk; o.bz = bz;
      return o;
   endfunction

   function void add(input bit tog, input bit nxt, input bit prv, input bit sv, input int sc,
                     input bit pwr, input int v, input bit se, input int c, input bit dk, input bit bz);
      vec_t r;
      r.tog = tog; r.nxt = nxt; r.prv = prv; r.sv = sv; r.sc = 3'(sc); r.pwr = pwr;
      r.exp = mk(v, se, c, dk, bz);
      tbl.push_back(r);
   endfunction

   function void count_rows(input int v, input int hi, input int lo);
      for (int c = hi; c >= lo; c--) add(0, 0, 0, 0, 0, 0, v, c > 0, c, 0, c > 0);
   endfunction

   function void expect_out(input out_t o, input string n);
      sb_t e;
      e.o = o; e.name = n;
      sbq.push_back(e);
   endfunction

   task automatic chk(input string name, input out_t exp);
      out_t got;
      got = '{view_id, static_en, static_cnt, dark, busy};
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got view=%0d se=%0d cnt=%0d dark=%0d busy=%0d, want view=%0d se=%0d cnt=%0d dark=%0d busy=%0d",
                  name, got.v, got.se, got.c, got.dk, got.bz, exp.v, exp.se, exp.c, exp.dk, exp.bz);
      end
   endtask

   task automatic step();
      sb_t e;
      @(negedge vga_clk);
      if (!Reset && prev_tick) begin
         total++;
         if (frame_tick !== 1'b0) begin
            bad++;
            $display("FAIL tick_width: frame_tick=%0b want 0 in cycle after tick", frame_tick);
         end
      end
      if (frame_tick === 1'b1 && sbq.size() > 0) begin
         e = sbq.pop_front();
         chk(e.name, e.o);
         $display("tick %s: view=%0d se=%0d cnt=%0d dark=%0d busy=%0d", e.name, view_id, static_en, static_cnt, dark, busy);
      end
      prev_tick = frame_tick;
   endtask

   task automatic wait_cnt(input logic [3:0] v);
      int n = 0;
      do begin
         step();
         n++;
      end while (cnt != v && n < 64);
      if (cnt != v) begin
         total++; bad++;
         $display("FAIL raster_wait: cnt=%0d want %0d", cnt, v);
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sbq.size() > 0 && n < 48) begin
         step();
         n++;
      end
      if (sbq.size() > 0) begin
         total++; bad++;
         $display("FAIL tick_timeout: pending=%0d want 0", sbq.size());
         sbq.delete();
      end
   endtask

   task automatic pulse(input logic tog, input logic nxt, input logic prv, input logic sv, input logic [2:0] sc);
      cam_toggle = tog; cam_next = nxt; cam_prev = prv; sel_valid = sv; sel_cam = sc;
      step();
      cam_toggle = 1'b0; cam_next = 1'b0; cam_prev = 1'b0; sel_valid = 1'b0; sel_cam = 3'd0;
   endtask

   task automatic run_range(input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         wait_cnt(4'd6);
         power_out = tbl[i].pwr;
         expect_out(tbl[i].exp, $sformatf("vec%0d", i));
         pulse(tbl[i].tog, tbl[i].nxt, tbl[i].prv, tbl[i].sv, tbl[i].sc);
         wait_drain();
      end
   endtask

   initial begin
      // open monitor on cam 0 and count the static down
      add(1, 0, 0, 0, 0, 0, 1, 1, 8, 0, 1);
      count_rows(1, 7, 0);
      // direct select to cam 5, then wrap forward and backward
      add(0, 0, 0, 1, 5, 0, 6, 1, 8, 0, 1);
      count_rows(6, 7, 0);
      add(0, 1, 0, 0, 0, 0, 1, 1, 8, 0, 1);
      count_rows(1, 7, 0);
      add(0, 0, 1, 0, 0, 0, 6, 1, 8, 0, 1);
      count_rows(6, 7, 0);
      // select beats next; out-of-range and same-camera selects do nothing
      add(0, 1, 0, 1, 3, 0, 4, 1, 8, 0, 1);
      count_rows(4, 7, 0);
      add(0, 0, 0, 1, 7, 0, 4, 0, 0, 0, 0);
      add(0, 0, 0, 1, 3, 0, 4, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0);
      // toggle + nav queued during OPEN: toggle wins on first VIEW tick
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 4, 1, 8, 0, 1);
      add(1, 1, 0, 0, 0, 0, 4, 1, 7, 0, 1);
      count_rows(4, 6, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 4, 1, 8, 0, 1);
      count_rows(4, 7, 0);
      // power loss: pulses ignored, nothing replayed on restore
      add(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
      add(1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0);
      add(0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 4, 1, 8, 0, 1);
      count_rows(4, 7, 3);
      split1 = tbl.size();
      count_rows(1, 7, 0);
      split2 = tbl.size();
      count_rows(3, 7, 0);

      repeat (4) step();
      chk("reset", '0);
      Reset = 1'b0;

      run_range(0, split1);

      // reset mid-transition, then a toggle landing exactly on the tick edge
      wait_cnt(4'd6);
      Reset = 1'b1;
      step();
      chk("reset_mid", '0);
      Reset = 1'b0;
      wait_cnt(4'd0);
      cam_toggle = 1'b1;
      expect_out(mk(0, 0, 0, 0, 0), "tick_pulse_held");
      step();
      cam_toggle = 1'b0;
      wait_drain();
      expect_out(mk(1, 1, 8, 0, 1), "tick_pulse_served");
      wait_drain();

      run_range(split1, split2);

      // several navs in one frame chain through the pending target
      wait_cnt(4'd4);
      expect_out(mk(3, 1, 8, 0, 1), "nav_chain");
      pulse(0, 1, 0, 0, 0);
      pulse(0, 1, 0, 0, 0);
      pulse(0, 0, 1, 0, 0);
      pulse(0, 1, 0, 0, 0);
      wait_drain();

      run_range(split2, tbl.size());

      // a later next steps from the selected target, wrapping 5 -> 0
      wait_cnt(4'd6);
      expect_out(mk(1, 1, 8, 0, 1), "sel_then_next");
      pulse(0, 0, 0, 1, 3'd5);
      pulse(0, 1, 0, 0, 0);
      wait_drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
